// File: rtl/dcache_write_buffer_pkg.sv
// rtl/dcache_write_buffer_pkg.sv - shared memory-system widths and write-buffer FSM encoding
package dcache_write_buffer_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        RD_MEM  = 2'd2,
        RD_DONE = 2'd3
    } wb_state_e;

endpackage

// File: rtl/dcache_write_buffer_if.sv
// rtl/dcache_write_buffer_if.sv - cache-side and data-memory-side signal bundle of the write buffer
interface dcache_write_buffer_if #(
    parameter int DEPTH = 4
);
    import dcache_write_buffer_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writeData;
    logic [DATA_W-1:0] mem_readData;
    logic              mem_busywait;

    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_address;
    logic [DATA_W-1:0] dm_writeData;
    logic [DATA_W-1:0] dm_readData;
    logic              dm_busywait;

    logic [CNT_W-1:0]  count;

    modport slave (
        input  mem_read, mem_write, mem_address, mem_writeData, dm_readData, dm_busywait,
        output mem_readData, mem_busywait, dm_read, dm_write, dm_address, dm_writeData, count
    );

    modport master (
        output mem_read, mem_write, mem_address, mem_writeData, dm_readData, dm_busywait,
        input  mem_readData, mem_busywait, dm_read, dm_write, dm_address, dm_writeData, count
    );

endinterface

// File: rtl/dcache_write_buffer_wb_fifo.sv
// rtl/dcache_write_buffer_wb_fifo.sv - posted-write FIFO with associative youngest-match lookup
module wb_fifo
    import dcache_write_buffer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              hit_o,
    output logic [DATA_W-1:0] hit_data_o
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok;
    logic              pop_ok;

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign push_ok     = push_i && !full_o;
    assign pop_ok      = pop_i && !empty_o;
    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];
    assign count_o     = count_q;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            addr_q[tail_q] <= push_addr_i;
            data_q[tail_q] <= push_data_i;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (pop_ok) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Walk oldest to youngest so the last match found is the youngest copy of the address.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && (addr_q[idx] == lookup_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[idx];
            end
        end
    end

endmodule

// File: rtl/dcache_write_buffer.sv
// rtl/dcache_write_buffer.sv - posted write buffer between data cache and data memory
module dcache_write_buffer #(
    parameter int DEPTH = 4
) (
    input logic                   clock,
    input logic                   reset,
    dcache_write_buffer_if.slave  bus
);
    import dcache_write_buffer_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_state_e         state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              full, empty, hit, pop;
    logic              rd_req, fwd;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data, hit_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              dm_read, dm_write;
    logic [ADDR_W-1:0] dm_address;

    // A simultaneous write wins, so the read side only ever sees a clean read request.
    assign rd_req = bus.mem_read && !bus.mem_write;
    assign fwd    = rd_req && hit;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push_i       (bus.mem_write),
        .push_addr_i  (bus.mem_address),
        .push_data_i  (bus.mem_writeData),
        .pop_i        (pop),
        .lookup_addr_i(bus.mem_address),
        .full_o       (full),
        .empty_o      (empty),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data),
        .count_o      (fifo_count),
        .hit_o        (hit),
        .hit_data_o   (hit_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        dm_read    = 1'b0;
        dm_write   = 1'b0;
        dm_address = head_addr;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_req && !hit) begin
                    state_d = RD_MEM;
                end else if (!empty) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                dm_write = 1'b1;
                if (!bus.dm_busywait) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            RD_MEM: begin
                dm_read    = 1'b1;
                dm_address = bus.mem_address;
                if (!bus.dm_busywait) begin
                    rdata_d = bus.dm_readData;
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.dm_read      = dm_read;
    assign bus.dm_write     = dm_write;
    assign bus.dm_address   = dm_address;
    assign bus.dm_writeData = head_data;
    assign bus.count        = fifo_count;
    assign bus.mem_readData = fwd ? hit_data : rdata_q;

    // Held low through reset so a cache stalled at reset is released cleanly.
    assign bus.mem_busywait = reset &&
                              ((bus.mem_write && full) ||
                               (rd_req && !hit && (state_q != RD_DONE)));

    a_no_read_write_overlap: assert property (
        @(posedge clock) disable iff (!reset) !(bus.mem_read && bus.mem_write)
    );

endmodule
